// File: rtl/y86_execute_stage.sv
// y86_execute_stage
// Registered execute stage of the Y86-64 pipeline. Accepts one decoded
// instruction per cycle over valid/ready, computes valE, owns the ZF/SF/OF
// condition-code register and resolves the jXX/cmovXX condition. Results are
// presented to the memory stage one cycle after acceptance.
module y86_execute_stage #(
   parameter int         W     = 64,
   parameter logic [3:0] RNONE = 4'hF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [3:0]   icode,
   input  logic [3:0]   ifun,
   input  logic [W-1:0] valA,
   input  logic [W-1:0] valB,
   input  logic [W-1:0] valC,
   input  logic [3:0]   dstE_in,
   input  logic         cc_freeze,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] valE,
   output logic         cnd,
   output logic [3:0]   dstE_out,
   output logic [3:0]   icode_out,
   output logic [W-1:0] valA_out,
   output logic         zf,
   output logic         sf,
   output logic         of,
   output logic         err
);

   typedef enum logic [3:0] {
      I_HALT   = 4'h0,
      I_NOP    = 4'h1,
      I_RRMOVQ = 4'h2,
      I_IRMOVQ = 4'h3,
      I_RMMOVQ = 4'h4,
      I_MRMOVQ = 4'h5,
      I_OPQ    = 4'h6,
      I_JXX    = 4'h7,
      I_CALL   = 4'h8,
      I_RET    = 4'h9,
      I_PUSHQ  = 4'hA,
      I_POPQ   = 4'hB
   } icode_e;

   typedef enum logic [3:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_AND = 4'h2,
      ALU_XOR = 4'h3
   } alu_fn_e;

   localparam logic [W-1:0] STACK_STEP = W'(8);

   // Condition evaluation for jXX/cmovXX from the current flags.
   function automatic logic cond_eval(input logic [3:0] fn, input logic z,
                                      input logic s, input logic o);
      logic c;
      c = 1'b0;
      case (fn)
         4'h0:    c = 1'b1;
         4'h1:    c = (s ^ o) | z;
         4'h2:    c = s ^ o;
         4'h3:    c = z;
         4'h4:    c = !z;
         4'h5:    c = !(s ^ o);
         4'h6:    c = !(s ^ o) && !z;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

   // Registered state
   logic         out_valid_q;
   logic [W-1:0] vale_q;
   logic         cnd_q;
   logic [3:0]   dste_q;
   logic [3:0]   icode_q;
   logic [W-1:0] vala_q;
   logic         err_q;
   logic         zf_q, sf_q, of_q;

   // Next-state values
   logic [W-1:0] vale_d;
   logic         err_d;
   logic         cc_wr;
   logic         zf_d, sf_d, of_d;
   logic         cnd_d;
   logic [3:0]   dste_d;
   logic         accept;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // ALU, flag generation and condition resolution for the presented instruction
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      vale_d = '0;
      err_d  = 1'b0;
      cc_wr  = 1'b0;
      of_d   = 1'b0;
      case (icode_e'(icode))
         I_RRMOVQ: vale_d = valA;
         I_IRMOVQ: vale_d = valC;
         I_RMMOVQ,
         I_MRMOVQ: vale_d = valB + valC;
         I_OPQ: begin
            cc_wr = 1'b1;
            // NOTE: blocking assignments here, so vale_d below already holds this cycle's result.
            case (alu_fn_e'(ifun))
               ALU_ADD: begin
                  vale_d = valB + valA;
                  of_d   = (valA[W-1] == valB[W-1]) && (vale_d[W-1] != valB[W-1]);
               end
               ALU_SUB: begin
                  vale_d = valB - valA;
                  of_d   = (valA[W-1] != valB[W-1]) && (vale_d[W-1] != valB[W-1]);
               end
               ALU_AND: vale_d = valB & valA;
               ALU_XOR: vale_d = valB ^ valA;
               default: begin
                  err_d = 1'b1;
                  cc_wr = 1'b0;
               end
            endcase
         end
         I_CALL,
         I_PUSHQ: vale_d = valB - STACK_STEP;
         I_RET,
         I_POPQ:  vale_d = valB + STACK_STEP;
         default: vale_d = '0;
      endcase
      zf_d = (vale_d == '0);
      sf_d = vale_d[W-1];
      // Condition is taken from the CC register as it stands before this edge,
      // which already reflects any OPq accepted on the previous edge.
      cnd_d = ((icode == I_RRMOVQ) || (icode == I_JXX)) ? cond_eval(ifun, zf_q, sf_q, of_q) : 1'b0;
      dste_d = ((icode == I_RRMOVQ) && !cnd_d) ? RNONE : dstE_in;
   end

   // Output register: load on accept, drop valid when consumed with nothing new
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: only control and architectural state need reset; here every field has a defined reset value so the memory stage sees a clean nop.
         out_valid_q <= 1'b0;
         vale_q      <= '0;
         cnd_q       <= 1'b0;
         dste_q      <= RNONE;
         icode_q     <= I_NOP;
         vala_q      <= '0;
         err_q       <= 1'b0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         vale_q      <= vale_d;
         cnd_q       <= cnd_d;
         dste_q      <= dste_d;
         icode_q     <= icode;
         vala_q      <= valA;
         err_q       <= err_d;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   // Condition-code register: written only by an accepted, unfrozen OPq
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         zf_q <= 1'b1;
         sf_q <= 1'b0;
         of_q <= 1'b0;
      end else if (accept && cc_wr && !cc_freeze) begin
         zf_q <= zf_d;
         sf_q <= sf_d;
         of_q <= of_d;
      end
   end

   assign out_valid = out_valid_q;
   assign valE      = vale_q;
   assign cnd       = cnd_q;
   assign dstE_out  = dste_q;
   assign icode_out = icode_q;
   assign valA_out  = vala_q;
   assign err       = err_q;
   assign zf        = zf_q;
   assign sf        = sf_q;
   assign of        = of_q;

endmodule

// File: tb/tb_y86_execute_stage.sv
// tb_y86_execute_stage
// Directed test of the Y86-64 execute stage: reset values, ALU results and
// flags, branch/cmov conditions, stack/address arithmetic, stall, CC freeze,
// error flag and asynchronous reset mid-stall.
module tb_y86_execute_stage;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  icode = 4'h1;
   logic [3:0]  ifun = 4'h0;
   logic [63:0] valA = '0;
   logic [63:0] valB = '0;
   logic [63:0] valC = '0;
   logic [3:0]  dstE_in = 4'hF;
   logic        cc_freeze = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] valE;
   logic        cnd;
   logic [3:0]  dstE_out;
   logic [3:0]  icode_out;
   logic [63:0] valA_out;
   logic        zf, sf, of;
   logic        err;

   int checks = 0;
   int errors = 0;

   y86_execute_stage #(.W(64), .RNONE(4'hF)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .icode     (icode),
      .ifun      (ifun),
      .valA      (valA),
      .valB      (valB),
      .valC      (valC),
      .dstE_in   (dstE_in),
      .cc_freeze (cc_freeze),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .valE      (valE),
      .cnd       (cnd),
      .dstE_out  (dstE_out),
      .icode_out (icode_out),
      .valA_out  (valA_out),
      .zf        (zf),
      .sf        (sf),
      .of        (of),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Present one instruction, wait (bounded) until accepted, sample 1 after the edge.
   task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [3:0] dst,
                        input logic frz);
      int n;
      icode = ic; ifun = fn; valA = a; valB = b; valC = c; dstE_in = dst; cc_freeze = frz;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL issue_timeout in_ready got %b exp 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      cc_freeze = 1'b0;
   endtask

   task automatic test_reset;
      checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (valE !== 64'h0)        begin errors++; $display("FAIL rst_valE got %h exp 0", valE); end
      checks++; if (cnd !== 1'b0)          begin errors++; $display("FAIL rst_cnd got %b exp 0", cnd); end
      checks++; if (dstE_out !== 4'hF)     begin errors++; $display("FAIL rst_dstE got %h exp F", dstE_out); end
      checks++; if (icode_out !== 4'h1)    begin errors++; $display("FAIL rst_icode got %h exp 1", icode_out); end
      checks++; if (valA_out !== 64'h0)    begin errors++; $display("FAIL rst_valA_out got %h exp 0", valA_out); end
      checks++; if (err !== 1'b0)          begin errors++; $display("FAIL rst_err got %b exp 0", err); end
      checks++; if ({zf, sf, of} !== 3'b100) begin errors++; $display("FAIL rst_cc got %b exp 100", {zf, sf, of}); end
      checks++; if (in_ready !== 1'b1)     begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_sub_overflow;
      issue(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 4'h2, 1'b0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL subovf_valid got %b exp 1", out_valid); end
      checks++; if (valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL subovf_valE got %h exp 7fffffffffffffff", valE); end
      checks++; if ({zf, sf, of} !== 3'b001) begin errors++; $display("FAIL subovf_cc got %b exp 001", {zf, sf, of}); end
      checks++; if (dstE_out !== 4'h2) begin errors++; $display("FAIL subovf_dstE got %h exp 2", dstE_out); end
      checks++; if (valA_out !== 64'h1) begin errors++; $display("FAIL subovf_valA_out got %h exp 1", valA_out); end
   endtask

   task automatic test_add_branch;
      issue(4'h6, 4'h0, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 4'h3, 1'b0);
      checks++; if (valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL addovf_valE got %h exp 8000000000000000", valE); end
      checks++; if ({zf, sf, of} !== 3'b011) begin errors++; $display("FAIL addovf_cc got %b exp 011", {zf, sf, of}); end
      issue(4'h7, 4'h2, 64'h0, 64'h0, 64'h400, 4'hF, 1'b0);
      checks++; if (cnd !== 1'b0) begin errors++; $display("FAIL jl_cnd got %b exp 0", cnd); end
      checks++; if (icode_out !== 4'h7) begin errors++; $display("FAIL jl_icode got %h exp 7", icode_out); end
      issue(4'h7, 4'h1, 64'h0, 64'h0, 64'h400, 4'hF, 1'b0);
      checks++; if (cnd !== 1'b0) begin errors++; $display("FAIL jle_cnd got %b exp 0", cnd); end
      issue(4'h7, 4'h5, 64'h0, 64'h0, 64'h400, 4'hF, 1'b0);
      checks++; if (cnd !== 1'b1) begin errors++; $display("FAIL jge_cnd got %b exp 1", cnd); end
      issue(4'h7, 4'h0, 64'h0, 64'h0, 64'h400, 4'hF, 1'b0);
      checks++; if (cnd !== 1'b1) begin errors++; $display("FAIL jmp_cnd got %b exp 1", cnd); end
   endtask

   task automatic test_cmov;
      issue(4'h6, 4'h1, 64'd69, 64'd420, 64'h0, 4'h4, 1'b0);
      checks++; if (valE !== 64'd351) begin errors++; $display("FAIL cmovsub_valE got %0d exp 351", valE); end
      checks++; if ({zf, sf, of} !== 3'b000) begin errors++; $display("FAIL cmovsub_cc got %b exp 000", {zf, sf, of}); end
      issue(4'h2, 4'h3, 64'h55, 64'h0, 64'h0, 4'h3, 1'b0);
      checks++; if (cnd !== 1'b0) begin errors++; $display("FAIL cmove_cnd got %b exp 0", cnd); end
      checks++; if (dstE_out !== 4'hF) begin errors++; $display("FAIL cmove_dstE got %h exp F", dstE_out); end
      checks++; if (valE !== 64'h55) begin errors++; $display("FAIL cmove_valE got %h exp 55", valE); end
      issue(4'h2, 4'h4, 64'h66, 64'h0, 64'h0, 4'h3, 1'b0);
      checks++; if ({cnd, dstE_out} !== 5'b1_0011) begin errors++; $display("FAIL cmovne got cnd %b dst %h exp 1 3", cnd, dstE_out); end
      issue(4'h2, 4'h6, 64'h77, 64'h0, 64'h0, 4'h5, 1'b0);
      checks++; if ({cnd, dstE_out} !== 5'b1_0101) begin errors++; $display("FAIL cmovg got cnd %b dst %h exp 1 5", cnd, dstE_out); end
   endtask

   task automatic test_stack_addr;
      issue(4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 1'b0);
      checks++; if (valE !== 64'hF8) begin errors++; $display("FAIL pushq_valE got %h exp f8", valE); end
      issue(4'hB, 4'h0, 64'h0, 64'h100, 64'h0, 4'h4, 1'b0);
      checks++; if (valE !== 64'h108) begin errors++; $display("FAIL popq_valE got %h exp 108", valE); end
      issue(4'h5, 4'h0, 64'h0, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8, 4'hF, 1'b0);
      checks++; if (valE !== 64'h8) begin errors++; $display("FAIL mrmovq_valE got %h exp 8", valE); end
      issue(4'h8, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 1'b0);
      checks++; if (valE !== 64'h1F8) begin errors++; $display("FAIL call_valE got %h exp 1f8", valE); end
      issue(4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 4'h1, 1'b0);
      checks++; if (valE !== 64'h1234) begin errors++; $display("FAIL irmovq_valE got %h exp 1234", valE); end
      checks++; if ({zf, sf, of} !== 3'b000) begin errors++; $display("FAIL stack_cc got %b exp 000", {zf, sf, of}); end
   endtask

   task automatic test_err;
      issue(4'h6, 4'h7, 64'h1, 64'h2, 64'h0, 4'h2, 1'b0);
      checks++; if ({err, valE} !== {1'b1, 64'h0}) begin errors++; $display("FAIL err_set got err %b valE %h exp 1 0", err, valE); end
      checks++; if ({zf, sf, of} !== 3'b000) begin errors++; $display("FAIL err_cc got %b exp 000", {zf, sf, of}); end
      issue(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 1'b0);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b exp 0", err); end
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_stall_freeze;
      issue(4'h6, 4'h3, 64'h5, 64'h3, 64'h0, 4'h2, 1'b0);
      checks++; if (valE !== 64'h6) begin errors++; $display("FAIL xor_valE got %h exp 6", valE); end
      out_ready = 1'b0;
      icode = 4'h6; ifun = 4'h1; valA = 64'h7; valB = 64'h7; dstE_in = 4'h2; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({in_ready, out_valid, valE, zf} !== {1'b0, 1'b1, 64'h6, 1'b0}) begin
            errors++;
            $display("FAIL stall_hold cyc %0d got rdy %b vld %b valE %h zf %b exp 0 1 6 0", i, in_ready, out_valid, valE, zf);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if ({valE, zf} !== {64'h0, 1'b1}) begin errors++; $display("FAIL stall_release got valE %h zf %b exp 0 1", valE, zf); end
      issue(4'h6, 4'h0, 64'h1, 64'h1, 64'h0, 4'h2, 1'b0);
      checks++; if ({valE, zf} !== {64'h2, 1'b0}) begin errors++; $display("FAIL add_nofrz got valE %h zf %b exp 2 0", valE, zf); end
      issue(4'h6, 4'h3, 64'h5, 64'h5, 64'h0, 4'h2, 1'b1);
      checks++; if (valE !== 64'h0) begin errors++; $display("FAIL frz_valE got %h exp 0", valE); end
      checks++; if ({zf, sf, of} !== 3'b000) begin errors++; $display("FAIL frz_cc got %b exp 000", {zf, sf, of}); end
   endtask

   task automatic test_reset_mid;
      issue(4'h3, 4'h0, 64'hAA, 64'h0, 64'h1234, 4'h2, 1'b0);
      out_ready = 1'b0;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b exp 1", out_valid); end
      reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
      checks++; if ({zf, sf, of} !== 3'b100) begin errors++; $display("FAIL midrst_cc got %b exp 100", {zf, sf, of}); end
      checks++; if ({valE, icode_out, dstE_out} !== {64'h0, 4'h1, 4'hF}) begin errors++; $display("FAIL midrst_regs got valE %h ic %h dst %h exp 0 1 F", valE, icode_out, dstE_out); end
      #2;
      reset_n = 1'b1;
      out_ready = 1'b1;
      issue(4'h6, 4'h2, 64'h0F, 64'hF0, 64'h0, 4'h2, 1'b0);
      checks++; if ({valE, zf, sf, of} !== {64'h0, 3'b100}) begin errors++; $display("FAIL and_after_rst got valE %h cc %b exp 0 100", valE, {zf, sf, of}); end
   endtask

   initial begin
      #12;
      test_reset;
      reset_n = 1'b1;
      @(posedge clk); #1;
      test_sub_overflow;
      test_add_branch;
      test_cmov;
      test_stack_addr;
      test_err;
      test_stall_freeze;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
